// File: rtl/button_conditioner.sv
// Debounces three code keys and one start key, and turns qualified presses into
// one-cycle pulses. Simultaneous code-key presses are resolved by highest index.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_WIDTH       = 20
) (
   input  logic       clk,
   input  logic       async_reset,
   input  logic [2:0] raw_buttons,
   input  logic       raw_start,
   output logic [2:0] buttons,
   output logic       start_trigger,
   output logic [3:0] pressed_level
);

   localparam int unsigned NUM_KEYS = 4;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      PRESS_PENDING   = 2'd1,
      PRESSED         = 2'd2,
      RELEASE_PENDING = 2'd3
   } state_e;

   logic [NUM_KEYS-1:0]  sync1_q, sync1_d;
   logic [NUM_KEYS-1:0]  sync2_q, sync2_d;
   logic [NUM_KEYS-1:0]  sample_c;
   state_e               state_q [NUM_KEYS];
   state_e               state_d [NUM_KEYS];
   logic [CNT_WIDTH-1:0] cnt_q   [NUM_KEYS];
   logic [CNT_WIDTH-1:0] cnt_d   [NUM_KEYS];
   logic [NUM_KEYS-1:0]  evt_q, evt_d;
   logic [NUM_KEYS-1:0]  level_q, level_d;
   logic [2:0]           buttons_q, buttons_d;
   logic                 start_q, start_d;

   // Two-flop synchronizer; keys idle high, so reset value is released.
   always_comb begin
      sync1_d  = {raw_start, raw_buttons};
      sync2_d  = sync1_q;
      sample_c = ~sync2_q;
   end

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // Per-key debounce FSM; evt_d marks the press-qualifying transition only.
   always_comb begin
      evt_d   = '0;
      level_d = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         case (state_q[k])
            RELEASED: begin
               if (sample_c[k]) begin
                  state_d[k] = PRESS_PENDING;
                  cnt_d[k]   = CNT_ONE;
               end
            end
            PRESS_PENDING: begin
               if (!sample_c[k]) begin
                  state_d[k] = RELEASED;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = PRESSED;
                  cnt_d[k]   = '0;
                  evt_d[k]   = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!sample_c[k]) begin
                  state_d[k] = RELEASE_PENDING;
                  cnt_d[k]   = CNT_ONE;
               end
            end
            RELEASE_PENDING: begin
               if (sample_c[k]) begin
                  state_d[k] = PRESSED;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = RELEASED;
                  cnt_d[k]   = '0;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
               end
            end
            default: begin
               state_d[k] = RELEASED;
               cnt_d[k]   = '0;
            end
         endcase
         level_d[k] = (state_q[k] == PRESSED) || (state_q[k] == RELEASE_PENDING);
      end
   end

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= RELEASED;
            cnt_q[k]   <= '0;
         end
         evt_q   <= '0;
         level_q <= '0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         evt_q   <= evt_d;
         level_q <= level_d;
      end
   end

   // Highest-index code key wins; lower simultaneous events are dropped.
   always_comb begin
      buttons_d = 3'b000;
      if (evt_q[2]) begin
         buttons_d = 3'b100;
      end else if (evt_q[1]) begin
         buttons_d = 3'b010;
      end else if (evt_q[0]) begin
         buttons_d = 3'b001;
      end
      start_d = evt_q[3];
   end

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         buttons_q <= 3'b000;
         start_q   <= 1'b0;
      end else begin
         buttons_q <= buttons_d;
         start_q   <= start_d;
      end
   end

   assign buttons       = buttons_q;
   assign start_trigger = start_q;
   assign pressed_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; pulses are
// checked against a queue of expected (cycle, buttons, start) entries.
module tb_button_conditioner;

   localparam int unsigned DEB = 4;
   localparam int unsigned CW  = 4;

   logic       clk = 1'b0;
   logic       async_reset;
   logic [2:0] raw_buttons;
   logic       raw_start;
   logic [2:0] buttons;
   logic       start_trigger;
   logic [3:0] pressed_level;

   typedef struct packed {
      int unsigned cyc;
      logic [2:0]  b;
      logic        s;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc;
   int unsigned vectors;
   int unsigned miscompares;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk          (clk),
      .async_reset  (async_reset),
      .raw_buttons  (raw_buttons),
      .raw_start    (raw_start),
      .buttons      (buttons),
      .start_trigger(start_trigger),
      .pressed_level(pressed_level)
   );

   task automatic push_exp(input int unsigned delay, input logic [2:0] b, input logic s);
      sb.push_back('{cyc: cyc + delay, b: b, s: s});
   endtask

   // Any pulse observed, or any entry falling due, is one scoreboard comparison.
   task automatic check_pulses();
      logic seen;
      exp_t e;
      seen = (buttons !== 3'b000) || (start_trigger !== 1'b0);
      if (seen || (sb.size() > 0 && sb[0].cyc == cyc)) begin
         vectors++;
         if (sb.size() == 0) begin
            assert ({buttons, start_trigger} === 4'b0000) else begin
               miscompares++;
               $error("FAIL spurious_pulse @%0d: observed buttons=%b start=%b, required none",
                      cyc, buttons, start_trigger);
            end
         end else begin
            e = sb.pop_front();
            assert ({cyc, buttons, start_trigger} === {e.cyc, e.b, e.s}) else begin
               miscompares++;
               $error("FAIL pulse: observed @%0d buttons=%b start=%b, required @%0d buttons=%b start=%b",
                      cyc, buttons, start_trigger, e.cyc, e.b, e.s);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_pulses();
   endtask

   task automatic run(input int unsigned n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_level(input string tag, input logic [3:0] exp);
      vectors++;
      assert (pressed_level === exp) else begin
         miscompares++;
         $error("FAIL %s @%0d: observed pressed_level=%b, required %b", tag, cyc, pressed_level, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      vectors++;
      assert ({buttons, start_trigger, pressed_level} === 8'h00) else begin
         miscompares++;
         $error("FAIL %s @%0d: observed buttons=%b start=%b level=%b, required all zero",
                tag, cyc, buttons, start_trigger, pressed_level);
      end
   endtask

   initial begin
      cyc         = 0;
      vectors     = 0;
      miscompares = 0;
      async_reset = 1'b0;
      raw_buttons = 3'b111;
      raw_start   = 1'b1;
      #3;
      chk_zero("reset_initial");
      run(3);
      chk_zero("reset_held");
      async_reset = 1'b1;
      run(4);
      chk_level("idle", 4'b0000);

      // Single press of key 1, held 20 cycles then released.
      raw_buttons[1] = 1'b0;
      push_exp(7, 3'b010, 1'b0);
      run(6);
      chk_level("single_before", 4'b0000);
      run(1);
      chk_level("single_level", 4'b0010);
      run(13);
      raw_buttons[1] = 1'b1;
      run(6);
      chk_level("single_release_wait", 4'b0010);
      run(1);
      chk_level("single_released", 4'b0000);

      // Bounce: 3 low, 1 high, then stable low.
      raw_buttons[0] = 1'b0;
      run(3);
      raw_buttons[0] = 1'b1;
      run(1);
      raw_buttons[0] = 1'b0;
      push_exp(7, 3'b001, 1'b0);
      run(10);
      raw_buttons[0] = 1'b1;
      run(8);
      chk_level("bounce_released", 4'b0000);

      // Simultaneous keys 2 and 0: only key 2 pulses, both held.
      raw_buttons = 3'b010;
      push_exp(7, 3'b100, 1'b0);
      run(7);
      chk_level("simul_level", 4'b0101);
      run(5);
      raw_buttons = 3'b111;
      run(8);
      chk_level("simul_released", 4'b0000);

      // Long hold, release, repress: exactly two pulses.
      raw_buttons[0] = 1'b0;
      push_exp(7, 3'b001, 1'b0);
      run(100);
      raw_buttons[0] = 1'b1;
      run(7);
      chk_level("repress_gap", 4'b0000);
      run(3);
      raw_buttons[0] = 1'b0;
      push_exp(7, 3'b001, 1'b0);
      run(12);
      chk_level("repress_held", 4'b0001);
      raw_buttons[0] = 1'b1;
      run(8);
      chk_level("repress_released", 4'b0000);

      // Start and key 1 together pulse in the same cycle.
      raw_start      = 1'b0;
      raw_buttons[1] = 1'b0;
      push_exp(7, 3'b010, 1'b1);
      run(7);
      chk_level("start_mix_level", 4'b1010);
      run(3);
      raw_start      = 1'b1;
      raw_buttons[1] = 1'b1;
      run(8);
      chk_level("start_mix_released", 4'b0000);

      // Reset mid-pending with another key already held.
      raw_buttons[0] = 1'b0;
      push_exp(7, 3'b001, 1'b0);
      run(10);
      chk_level("rst_pre_level", 4'b0001);
      raw_buttons[2] = 1'b0;
      run(5);
      async_reset = 1'b0;
      #2;
      chk_zero("rst_async");
      run(3);
      chk_zero("rst_hold");
      async_reset = 1'b1;
      push_exp(7, 3'b100, 1'b0);
      run(6);
      chk_level("rst_after_wait", 4'b0000);
      run(1);
      chk_level("rst_after_level", 4'b0101);
      run(2);
      raw_buttons = 3'b111;
      run(8);
      chk_level("rst_released", 4'b0000);

      run(5);
      vectors++;
      assert (sb.size() === 0) else begin
         miscompares++;
         $error("FAIL queue_drain: observed %0d pending pulses, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
